scroll_display: RTL and testbench
=================================

# scroll_display

Parametrised scrolling-message engine for the multi-digit seven-segment displays. Latches an N-character message, frames it with blank padding, and rotates the frame across `NUM_DIGITS` digit slots at a programmable tick rate, left or right, with pause, single-step and reload. Outputs per-digit character codes; the existing per-digit character decoders turn those codes into segments.

## Interface
- `NUM_DIGITS`, 8: display digit slots.
- `MSG_LEN`, 5: message characters, ≥1.
- `GAP`, 3: blank slots appended to the message; frame length L = MSG_LEN+GAP, L ≥ 2.
- `CHAR_W`, 3: bits per character code.
- `BLANK`, all-ones of `CHAR_W`: code for an empty digit.
- `TICK_DIV`, 50_000_000: CLOCK_50 cycles per scroll step, ≥1.

- `CLOCK_50` in 1: sole clock, rising edge.
- `Resetn` in 1: asynchronous, active-low reset.
- `Msg` in MSG_LEN*CHAR_W: message; char 0 = leftmost letter, at bits [CHAR_W-1:0].
- `Load` in 1: level; captures `Msg`, position to 0, divider to 0.
- `Enable` in 1: 1 = auto-scroll; 0 = pause (divider frozen).
- `Dir` in 1: 0 = scroll left (pos increments), 1 = scroll right (pos decrements).
- `Step` in 1: single-cycle pulse; advance one position regardless of `Enable`.
- `Disp` out NUM_DIGITS*CHAR_W: digit codes; leftmost digit in MSBs.
- `Pos` out clog2(L): current frame offset.
- `Wrap` out 1: one-cycle pulse when position wraps.

## Operation
- Frame slot s: `Msg` char s for s < MSG_LEN, else `BLANK`.
- Leftmost-counted digit k (k=0 leftmost) shows frame[(Pos+k) mod L]; mod by compare/subtract, never `%`.
- Divider counts 0..TICK_DIV-1 while `Enable`=1; tick asserted on terminal count, counter returns to 0. `Enable`=0 holds count.
- Advance event = tick OR `Step`; coincident tick and `Step` advance once.
- Left: Pos = (Pos==L-1) ? 0 : Pos+1. Right: Pos = (Pos==0) ? L-1 : Pos-1.
- `Wrap`=1 on the cycle after an advance that crosses L-1→0 (left) or 0→L-1 (right).
- Priority: `Load` > advance. `Load` held high keeps Pos=0, divider=0, no `Wrap`.
- Message shadow register changes only on `Load`; `Msg` changes otherwise ignored.
- `Dir` change mid-scroll: takes effect on next advance; Pos unchanged.

## Timing
- Reset (async assert, sync release): Pos=0, divider=0, shadow all `BLANK`, `Disp` all `BLANK`, `Wrap`=0.
- `Disp` registered: reflects Pos and shadow one cycle after they update (2 cycles after `Load`/advance edge).
- `Pos` and `Wrap` update on the edge that samples the advance event.
- First auto advance after `Load` deassert or reset: TICK_DIV enabled cycles later.
- TICK_DIV=1: advance every enabled cycle.
- Reset mid-scroll: immediate return to reset values; no pending advance survives.

## Structure
- Shared package: `BLANK` default, `CHAR_W` default, clog2-based width helper for Pos and divider.
- Sub-module `tick_divider` (parameter `TICK_DIV`; ports `CLOCK_50`, `Resetn`, `Enable`, `Clr`, `Tick`).
- Top: shadow register, position counter, generate loop of NUM_DIGITS slot selectors feeding `Disp` register.

## Test plan
(NUM_DIGITS=8, MSG_LEN=5, GAP=3, CHAR_W=3, TICK_DIV=4, BLANK=7.)
- Reset then `Load` with chars 0,1,2,3,4 → `Disp` left→right 0,1,2,3,4,7,7,7; Pos=0.
- `Enable`=1, `Dir`=0 → Pos advances every 4 cycles; after 8 advances Pos=0, `Wrap` one cycle; after first advance `Disp` = 1,2,3,4,7,7,7,0.
- `Dir`=1 from Pos=0 → next Pos=7, `Wrap` pulse; `Disp` = 7,0,1,2,3,4,7,7.
- `Enable`=0 for 20 cycles at divider=2 → Pos frozen; re-enable → advance after exactly 2 cycles.
- `Step` pulse while `Enable`=0 → Pos+1; `Step` coincident with tick → Pos+1 only.
- `Load` with new `Msg` at Pos=5, same cycle as tick → Pos=0, no advance, new chars on `Disp`; `Resetn` low mid-scroll → all outputs to reset values asynchronously.

Source files
------------

// File: rtl/scroll_display_pkg.sv
// ---------------------------------------------------------------------------
// scroll_display_pkg
//   Shared constants and elaboration-time helpers for the scrolling-message
//   engine.
//
//   CHAR_W_DEFAULT : default bits per character code.
//   BLANK_DEFAULT  : all-ones code that drives an empty digit.
//   width_for(n)   : clog2-based width of a counter holding values 0..n-1.
//                    Never returns less than one bit.
//   mod_sub(a, m)  : a mod m by repeated subtraction. Only used on constants
//                    at elaboration time.
// ---------------------------------------------------------------------------
package scroll_display_pkg;

  localparam int CHAR_W_DEFAULT = 3;
  localparam logic [CHAR_W_DEFAULT-1:0] BLANK_DEFAULT = '1;

  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int mod_sub(input int a, input int m);
    int r;
    r = a;
    while (r >= m) r = r - m;
    return r;
  endfunction

endpackage

// File: rtl/scroll_display_tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider
//   Free-running prescaler that produces one scroll tick every TICK_DIV
//   enabled clock cycles.
//
//   Parameters
//     TICK_DIV : enabled cycles per tick, >= 1.
//
//   Ports
//     CLOCK_50 : in  - clock, rising edge.
//     Resetn   : in  - asynchronous active-low reset.
//     Enable   : in  - 1 = count; 0 = hold the current count.
//     Clr      : in  - synchronous clear to 0. Wins over Enable and
//                      suppresses Tick.
//     Tick     : out - combinational; high while the count is terminal and
//                      counting is enabled.
// ---------------------------------------------------------------------------
module tick_divider
  import scroll_display_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic Resetn,
  input  logic Enable,
  input  logic Clr,
  output logic Tick
);

  localparam int CNT_W = width_for(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             terminal;

  assign terminal = (count_reg == CNT_LAST);

  // Tick is combinational. The advance is taken on the same edge that wraps
  // the count back to 0, so the first tick lands exactly TICK_DIV enabled
  // cycles after a clear.
  assign Tick = Enable && !Clr && terminal;

  always_comb begin
    count_next = count_reg;
    if (Clr) begin
      count_next = '0;
    end else if (Enable) begin
      if (terminal) begin
        count_next = '0;
      end else begin
        count_next = count_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/scroll_display.sv
// ---------------------------------------------------------------------------
// scroll_display
//   Scrolling-message engine for multi-digit seven-segment displays. It
//   latches an MSG_LEN-character message and appends GAP blank slots to form
//   a frame of L = MSG_LEN + GAP slots. It then rotates that frame across
//   NUM_DIGITS digit slots, one position per tick or Step pulse.
//
//   Parameters
//     NUM_DIGITS : digit slots on the display.
//     MSG_LEN    : message characters, >= 1.
//     GAP        : blank slots after the message (L >= 2).
//     CHAR_W     : bits per character code.
//     BLANK      : code for an empty digit (all ones by default).
//     TICK_DIV   : clock cycles per automatic scroll step, >= 1.
//
//   Ports
//     CLOCK_50 : in  - clock, rising edge.
//     Resetn   : in  - asynchronous active-low reset.
//     Msg      : in  - message; char 0 (leftmost) in bits [CHAR_W-1:0].
//     Load     : in  - level; captures Msg and clears position and divider.
//     Enable   : in  - 1 = auto-scroll, 0 = pause.
//     Dir      : in  - 0 = scroll left (Pos increments),
//                      1 = scroll right (Pos decrements).
//     Step     : in  - one-cycle pulse; advances one position.
//     Disp     : out - registered digit codes; leftmost digit in the MSBs.
//     Pos      : out - current frame offset.
//     Wrap     : out - one-cycle pulse after an advance that wraps Pos.
// ---------------------------------------------------------------------------
module scroll_display
  import scroll_display_pkg::*;
#(
  parameter int                NUM_DIGITS = 8,
  parameter int                MSG_LEN    = 5,
  parameter int                GAP        = 3,
  parameter int                CHAR_W     = CHAR_W_DEFAULT,
  parameter logic [CHAR_W-1:0] BLANK      = '1,
  parameter int                TICK_DIV   = 50_000_000
) (
  input  logic                               CLOCK_50,
  input  logic                               Resetn,
  input  logic [MSG_LEN*CHAR_W-1:0]          Msg,
  input  logic                               Load,
  input  logic                               Enable,
  input  logic                               Dir,
  input  logic                               Step,
  output logic [NUM_DIGITS*CHAR_W-1:0]       Disp,
  output logic [width_for(MSG_LEN+GAP)-1:0]  Pos,
  output logic                               Wrap
);

  localparam int L     = MSG_LEN + GAP;
  localparam int POS_W = width_for(L);
  // The sum of a position and a constant offset is below 2L, so one extra
  // bit is enough.
  localparam int IDX_W = width_for(2 * L);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(L - 1);

  // -------------------------------------------------------------------------
  // Scroll tick
  // -------------------------------------------------------------------------
  logic tick;
  logic advance;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .Enable   (Enable),
    .Clr      (Load),
    .Tick     (tick)
  );

  // A tick and a Step that coincide merge into a single advance.
  assign advance = tick || Step;

  // -------------------------------------------------------------------------
  // Message shadow register: loads only while Load is high.
  // -------------------------------------------------------------------------
  logic [CHAR_W-1:0] shadow_reg [MSG_LEN];

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        shadow_reg[i] <= BLANK;
      end
    end else if (Load) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        shadow_reg[i] <= Msg[i*CHAR_W +: CHAR_W];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Position counter and wrap flag
  // -------------------------------------------------------------------------
  logic [POS_W-1:0] pos_reg;
  logic [POS_W-1:0] pos_next;
  logic             wrap_reg;
  logic             wrap_next;

  always_comb begin
    pos_next  = pos_reg;
    wrap_next = 1'b0;
    if (Load) begin
      // Load outranks any advance in the same cycle and never flags a wrap.
      pos_next = '0;
    end else if (advance) begin
      if (!Dir) begin
        if (pos_reg == POS_LAST) begin
          pos_next  = '0;
          wrap_next = 1'b1;
        end else begin
          pos_next = pos_reg + POS_W'(1);
        end
      end else begin
        if (pos_reg == '0) begin
          pos_next  = POS_LAST;
          wrap_next = 1'b1;
        end else begin
          pos_next = pos_reg - POS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      pos_reg  <= '0;
      wrap_reg <= 1'b0;
    end else begin
      pos_reg  <= pos_next;
      wrap_reg <= wrap_next;
    end
  end

  assign Pos  = pos_reg;
  assign Wrap = wrap_reg;

  // -------------------------------------------------------------------------
  // Frame: message characters followed by GAP blank slots.
  // -------------------------------------------------------------------------
  logic [CHAR_W-1:0] frame [L];

  genvar gi;
  for (gi = 0; gi < L; gi++) begin : g_frame
    if (gi < MSG_LEN) begin : g_msg
      assign frame[gi] = shadow_reg[gi];
    end else begin : g_gap
      assign frame[gi] = BLANK;
    end
  end

  // -------------------------------------------------------------------------
  // Slot selectors. Digit k shows frame[(Pos + k) mod L]. The constant part
  // (k mod L) is folded at elaboration time. Because Pos < L, the run-time
  // wrap needs at most one compare and subtract.
  // -------------------------------------------------------------------------
  logic [CHAR_W-1:0] slot_code [NUM_DIGITS];

  for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
    localparam int K_MOD = mod_sub(gi, L);
    logic [IDX_W-1:0] sum;
    logic [POS_W-1:0] idx;

    assign sum = IDX_W'(pos_reg) + IDX_W'(K_MOD);
    assign idx = (sum >= IDX_W'(L)) ? POS_W'(sum - IDX_W'(L)) : POS_W'(sum);
    assign slot_code[gi] = frame[idx];
  end

  // -------------------------------------------------------------------------
  // Display register: digit 0 (leftmost) goes to the most significant field.
  // -------------------------------------------------------------------------
  logic [NUM_DIGITS*CHAR_W-1:0] disp_reg;
  logic [NUM_DIGITS*CHAR_W-1:0] disp_next;

  always_comb begin
    disp_next = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      disp_next[(NUM_DIGITS-1-k)*CHAR_W +: CHAR_W] = slot_code[k];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      disp_reg <= {NUM_DIGITS{BLANK}};
    end else begin
      disp_reg <= disp_next;
    end
  end

  assign Disp = disp_reg;

endmodule

// File: tb/tb_scroll_display.sv
// ---------------------------------------------------------------------------
// tb_scroll_display
//   Self-checking bench for scroll_display. It uses NUM_DIGITS=8, MSG_LEN=5,
//   GAP=3, CHAR_W=3, BLANK=7 and TICK_DIV=4. A table of directed rows is
//   followed by hand-written multi-cycle sequences and a randomized run. The
//   randomized run is checked against a frame/rotation reference model.
// ---------------------------------------------------------------------------
module tb_scroll_display;

  localparam int ND  = 8;
  localparam int ML  = 5;
  localparam int GP  = 3;
  localparam int CW  = 3;
  localparam int TD  = 4;
  localparam int LEN = ML + GP;
  localparam logic [CW-1:0] BL = 3'd7;

  logic               CLOCK_50 = 1'b0;
  logic               Resetn   = 1'b0;
  logic               Load     = 1'b0;
  logic               Enable   = 1'b0;
  logic               Dir      = 1'b0;
  logic               Step     = 1'b0;
  logic [ML*CW-1:0]   Msg      = '0;
  logic [ND*CW-1:0]   Disp;
  logic [2:0]         Pos;
  logic               Wrap;

  always #5 CLOCK_50 = ~CLOCK_50;

  scroll_display #(
    .NUM_DIGITS (ND),
    .MSG_LEN    (ML),
    .GAP        (GP),
    .CHAR_W     (CW),
    .BLANK      (BL),
    .TICK_DIV   (TD)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .Msg      (Msg),
    .Load     (Load),
    .Enable   (Enable),
    .Dir      (Dir),
    .Step     (Step),
    .Disp     (Disp),
    .Pos      (Pos),
    .Wrap     (Wrap)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int              m_pos;
  int              m_cnt;     // enabled cycles since the last tick or load
  bit              m_wrap;
  int              m_msg [ML];
  logic [ND*CW-1:0] m_disp;

  function automatic logic [ND*CW-1:0] view(input int pos);
    logic [ND*CW-1:0] v;
    int s;
    int c;
    v = '0;
    for (int k = 0; k < ND; k++) begin
      s = (pos + k) % LEN;
      c = (s < ML) ? m_msg[s] : int'(BL);
      v[(ND-1-k)*CW +: CW] = CW'(c);
    end
    return v;
  endfunction

  task automatic model_reset();
    m_pos  = 0;
    m_cnt  = 0;
    m_wrap = 1'b0;
    for (int i = 0; i < ML; i++) m_msg[i] = int'(BL);
    m_disp = {ND{BL}};
  endtask

  task automatic model_edge();
    bit tick;
    m_disp = view(m_pos);
    tick   = Enable && (m_cnt == TD - 1);
    if (Load) begin
      for (int i = 0; i < ML; i++) m_msg[i] = int'(Msg[i*CW +: CW]);
      m_pos  = 0;
      m_cnt  = 0;
      m_wrap = 1'b0;
    end else begin
      if (Enable) m_cnt = (m_cnt + 1) % TD;
      m_wrap = 1'b0;
      if (tick || Step) begin
        if (!Dir) begin
          m_wrap = (m_pos == LEN - 1);
          m_pos  = (m_pos + 1) % LEN;
        end else begin
          m_wrap = (m_pos == 0);
          m_pos  = (m_pos + LEN - 1) % LEN;
        end
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_pos"},  64'(Pos),  64'(m_pos));
    chk({tag, "_wrap"}, 64'(Wrap), 64'(m_wrap));
    chk({tag, "_disp"}, 64'(Disp), 64'(m_disp));
  endtask

  // One clock: the DUT and the model both consume the current inputs, and
  // the outputs are sampled 1 ns after the edge.
  task automatic cycle(input bit check, input string tag);
    @(posedge CLOCK_50);
    model_edge();
    #1;
    if (check) compare_model(tag);
  endtask

  function automatic logic [ND*CW-1:0] d8(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7);
    return {CW'(a0), CW'(a1), CW'(a2), CW'(a3), CW'(a4), CW'(a5), CW'(a6), CW'(a7)};
  endfunction

  function automatic logic [ML*CW-1:0] mk_msg(input int c0, input int c1, input int c2,
                                              input int c3, input int c4);
    return {CW'(c4), CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    bit               load;
    bit               en;
    bit               dir;
    bit               step;
    logic [ML*CW-1:0] msg;
    int               pos;
    bit               wrap;
    logic [ND*CW-1:0] disp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ML*CW-1:0] m01234;
    logic [ML*CW-1:0] junk;
    logic [ND*CW-1:0] v0;
    logic [ND*CW-1:0] v1;
    logic [ND*CW-1:0] v7;
    logic [ND*CW-1:0] vb;
    int wraps;

    m01234 = mk_msg(0, 1, 2, 3, 4);
    junk   = mk_msg(6, 6, 6, 6, 6);
    v0 = d8(0, 1, 2, 3, 4, 7, 7, 7);
    v1 = d8(1, 2, 3, 4, 7, 7, 7, 0);
    v7 = d8(7, 0, 1, 2, 3, 4, 7, 7);
    vb = d8(7, 7, 7, 7, 7, 7, 7, 7);

    //            load en dir step msg     pos wrap disp
    tbl[0]  = '{1, 0, 0, 0, m01234, 0, 0, vb};  // Disp still blank; lags by one
    tbl[1]  = '{0, 0, 0, 0, junk,   0, 0, v0};  // Msg change ignored
    tbl[2]  = '{0, 1, 0, 0, junk,   0, 0, v0};  // divider 0->1
    tbl[3]  = '{0, 1, 0, 0, junk,   0, 0, v0};  // 1->2
    tbl[4]  = '{0, 1, 0, 0, junk,   0, 0, v0};  // 2->3
    tbl[5]  = '{0, 1, 0, 0, junk,   1, 0, v0};  // tick: Pos 1
    tbl[6]  = '{0, 1, 0, 0, junk,   1, 0, v1};  // Disp catches up
    tbl[7]  = '{0, 0, 1, 1, junk,   0, 0, v1};  // step right 1->0
    tbl[8]  = '{0, 0, 1, 1, junk,   7, 1, v0};  // step right 0->7, wrap
    tbl[9]  = '{0, 0, 1, 0, junk,   7, 0, v7};
    tbl[10] = '{0, 0, 0, 1, junk,   0, 1, v7};  // step left 7->0, wrap
    tbl[11] = '{0, 0, 0, 0, junk,   0, 0, v0};

    // ---- reset ----
    model_reset();
    Resetn = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("rst_pos",  64'(Pos),  64'd0);
    chk("rst_wrap", 64'(Wrap), 64'd0);
    chk("rst_disp", 64'(Disp), 64'(vb));
    $display("reset pos=%0d wrap=%0b disp=%h", Pos, Wrap, Disp);
    Resetn = 1'b1;

    // ---- table ----
    for (int i = 0; i < 12; i++) begin
      Load   = tbl[i].load;
      Enable = tbl[i].en;
      Dir    = tbl[i].dir;
      Step   = tbl[i].step;
      Msg    = tbl[i].msg;
      cycle(0, "tbl");
      chk($sformatf("tbl%0d_pos", i),  64'(Pos),  64'(tbl[i].pos));
      chk($sformatf("tbl%0d_wrap", i), 64'(Wrap), 64'(tbl[i].wrap));
      chk($sformatf("tbl%0d_disp", i), 64'(Disp), 64'(tbl[i].disp));
      $display("row %0d load=%0b en=%0b dir=%0b step=%0b pos=%0d wrap=%0b disp=%h",
               i, Load, Enable, Dir, Step, Pos, Wrap, Disp);
    end
    Step = 1'b0;

    // ---- A: auto scroll left, one full lap ----
    Load = 1'b1; Enable = 1'b0; Dir = 1'b0; Msg = m01234;
    cycle(1, "A_load");
    Load = 1'b0; Enable = 1'b1;
    wraps = 0;
    for (int c = 1; c <= 32; c++) begin
      Msg = ML*CW'($urandom);
      cycle(1, "A");
      if (Wrap) wraps++;
      if (c == 5)  chk("A_disp_first_adv", 64'(Disp), 64'(v1));
      if (c == 32) chk("A_wrap_8th_adv", 64'(Wrap), 64'd1);
    end
    chk("A_wrap_count", 64'(wraps), 64'd1);
    chk("A_pos_end",    64'(Pos),   64'd0);
    $display("seqA lap pos=%0d wraps=%0d", Pos, wraps);

    // ---- B: pause at divider=2 ----
    Load = 1'b1; Enable = 1'b0;
    cycle(1, "B_load");
    Load = 1'b0; Enable = 1'b1;
    repeat (2) cycle(1, "B_run");
    Enable = 1'b0;
    repeat (20) cycle(1, "B_pause");
    chk("B_pos_frozen", 64'(Pos), 64'd0);
    Enable = 1'b1;
    cycle(1, "B_re1");
    chk("B_re1_pos", 64'(Pos), 64'd0);
    cycle(1, "B_re2");
    chk("B_re2_pos", 64'(Pos), 64'd1);
    $display("seqB pause/resume pos=%0d", Pos);

    // ---- C: step while paused, step coincident with tick ----
    Load = 1'b1; Enable = 1'b0;
    cycle(1, "C_load");
    Load = 1'b0; Step = 1'b1;
    cycle(1, "C_step");
    chk("C_step_pos", 64'(Pos), 64'd1);
    Step = 1'b0; Enable = 1'b1;
    repeat (3) cycle(1, "C_run");
    Step = 1'b1;
    cycle(1, "C_coinc");
    chk("C_coinc_pos", 64'(Pos), 64'd2);
    Step = 1'b0;
    cycle(1, "C_after");
    chk("C_after_pos", 64'(Pos), 64'd2);
    $display("seqC step pos=%0d", Pos);

    // ---- D: Load on the same cycle as a tick, at Pos=5 ----
    Load = 1'b1; Enable = 1'b0; Msg = m01234;
    cycle(1, "D_load");
    Load = 1'b0; Enable = 1'b1;
    repeat (23) cycle(1, "D_run");
    chk("D_pos5", 64'(Pos), 64'd5);
    Load = 1'b1; Msg = mk_msg(6, 5, 4, 3, 2);
    cycle(1, "D_reload");
    chk("D_reload_pos",  64'(Pos),  64'd0);
    chk("D_reload_wrap", 64'(Wrap), 64'd0);
    Load = 1'b0; Enable = 1'b0;
    cycle(1, "D_view");
    chk("D_new_disp", 64'(Disp), 64'(d8(6, 5, 4, 3, 2, 7, 7, 7)));
    $display("seqD reload pos=%0d disp=%h", Pos, Disp);

    // ---- E: asynchronous reset mid-scroll ----
    Enable = 1'b1;
    repeat (10) cycle(1, "E_run");
    chk("E_pos_pre", 64'(Pos), 64'd2);
    @(posedge CLOCK_50);
    model_edge();
    #3;
    Resetn = 1'b0;
    #1;
    model_reset();
    chk("E_async_pos",  64'(Pos),  64'd0);
    chk("E_async_wrap", 64'(Wrap), 64'd0);
    chk("E_async_disp", 64'(Disp), 64'(vb));
    @(posedge CLOCK_50);
    #1;
    compare_model("E_held");
    Resetn = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cycle(1, "E_post");
      if (c == 3) chk("E_no_early_adv", 64'(Pos), 64'd0);
      if (c == 4) chk("E_first_adv",    64'(Pos), 64'd1);
    end
    $display("seqE reset mid-scroll pos=%0d", Pos);

    // ---- F: randomized run against the model ----
    for (int c = 0; c < 2000; c++) begin
      Load   = ($urandom_range(0, 39) == 0);
      Enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) Dir = ~Dir;
      Step   = ($urandom_range(0, 9) == 0);
      Msg    = ML*CW'($urandom);
      cycle(1, "F");
    end
    $display("seqF random done checks=%0d", checks);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
